// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared encodings for the two-requester round-robin arbiter
package arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux2_word.sv
// rtl/mux2_word.sv - WIDTH-bit 2:1 mux built per bit from not/and/or gates
module mux2_word #(
    parameter int WIDTH = 8
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    logic w_nsel;

    assign w_nsel = ~i_sel;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        logic w_pick_a;
        logic w_pick_b;
        assign w_pick_a = w_nsel & i_a[g];
        assign w_pick_b = i_sel  & i_b[g];
        assign o_y[g]   = w_pick_a | w_pick_b;
    end
endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin owner of a shared 2:1 mux onto one valid/ready channel
module mux2_rr_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             out_ready,
    output logic             sel,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [BW-1:0] r_beat_cnt;
    logic [BW-1:0] w_beat_nxt;
    logic          r_sel;
    logic          w_sel_nxt;
    logic          r_last_served;
    logic          w_last_nxt;
    logic          w_xfer;

    assign gnt_a     = (r_state == ST_GNT_A);
    assign gnt_b     = (r_state == ST_GNT_B);
    assign sel       = r_sel;
    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign w_xfer    = out_valid & out_ready;
    assign ack_a     = w_xfer & gnt_a;
    assign ack_b     = w_xfer & gnt_b;

    mux2_word #(.WIDTH(WIDTH)) u_mux (
        .i_sel (r_sel),
        .i_a   (data_a),
        .i_b   (data_b),
        .o_y   (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_beat_cnt    <= '0;
            r_sel         <= SEL_A;
            r_last_served <= SEL_B;
        end else begin
            r_state       <= w_state_nxt;
            r_beat_cnt    <= w_beat_nxt;
            r_sel         <= w_sel_nxt;
            r_last_served <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                w_beat_nxt = '0;
                if (req_a && req_b)
                    w_state_nxt = (r_last_served == SEL_B) ? ST_GNT_A : ST_GNT_B;
                else if (req_a)
                    w_state_nxt = ST_GNT_A;
                else if (req_b)
                    w_state_nxt = ST_GNT_B;
            end
            ST_GNT_A: begin
                if (!req_a) begin
                    w_state_nxt = req_b ? ST_GNT_B : ST_IDLE;
                    w_beat_nxt  = '0;
                end else if (w_xfer) begin
                    // Burst exhausted: hand over if B waits, otherwise start a fresh burst
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_beat_nxt = '0;
                        if (req_b)
                            w_state_nxt = ST_GNT_B;
                    end else begin
                        w_beat_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            ST_GNT_B: begin
                if (!req_b) begin
                    w_state_nxt = req_a ? ST_GNT_A : ST_IDLE;
                    w_beat_nxt  = '0;
                end else if (w_xfer) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_beat_nxt = '0;
                        if (req_a)
                            w_state_nxt = ST_GNT_A;
                    end else begin
                        w_beat_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    // sel and the round-robin pointer follow the owner; IDLE keeps the previous select
    always_comb begin
        w_sel_nxt  = r_sel;
        w_last_nxt = r_last_served;
        if (w_state_nxt == ST_GNT_A) begin
            w_sel_nxt  = SEL_A;
            w_last_nxt = SEL_A;
        end else if (w_state_nxt == ST_GNT_B) begin
            w_sel_nxt  = SEL_B;
            w_last_nxt = SEL_B;
        end
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - directed self-checking bench for mux2_rr_arbiter
module tb_mux2_rr_arbiter;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             out_ready;
    logic             sel;
    logic             gnt_a;
    logic             gnt_b;
    logic             ack_a;
    logic             ack_b;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    int n_pass;
    int n_total;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic e_ga, input logic e_gb, input logic e_sel,
                           input logic e_val, input logic e_aa, input logic e_ab);
        chk({tag, ".gnt_a"}, 32'(gnt_a), 32'(e_ga));
        chk({tag, ".gnt_b"}, 32'(gnt_b), 32'(e_gb));
        chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_val));
        chk({tag, ".ack_a"}, 32'(ack_a), 32'(e_aa));
        chk({tag, ".ack_b"}, 32'(ack_b), 32'(e_ab));
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        req_a     = 1'b1;
        req_b     = 1'b1;
        data_a    = 8'hA5;
        data_b    = 8'h5A;
        out_ready = 1'b1;

        // Reset held with both requesting
        for (int i = 0; i < 2; i++) begin
            step();
            chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;

        // Contention: tie after reset goes to A, then A x4, B x4, A x4
        step();
        for (int i = 0; i < 12; i++) begin
            logic ea;
            ea = ((i / 4) % 2) == 0;
            chk_ctl($sformatf("rr%0d", i), ea, !ea, !ea, 1'b1, ea, !ea);
            chk($sformatf("rr%0d.data", i), 32'(out_data), ea ? 32'hA5 : 32'h5A);
            chk($sformatf("rr%0d.beat", i), 32'(dut.r_beat_cnt), 32'(i % 4));
            step();
        end

        // Backpressure in GNT_B: stall three cycles, nothing counted
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl($sformatf("stall%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("stall%0d.data", i), 32'(out_data), 32'h5A);
            chk($sformatf("stall%0d.beat", i), 32'(dut.r_beat_cnt), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_ctl($sformatf("resume%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            step();
        end
        chk_ctl("after_resume", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Early release by A after two beats hands straight to B
        step();
        step();
        chk("early.beat", 32'(dut.r_beat_cnt), 32'd2);
        req_a = 1'b0;
        #1;
        chk_ctl("early_drop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_ctl("early_b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("early_b.beat", 32'(dut.r_beat_cnt), 32'd0);

        // Asynchronous reset between edges during GNT_B
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctl("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        req_b = 1'b0;
        req_a = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single requester: six back-to-back acks, burst counter wraps without a gap
        for (int i = 0; i < 6; i++) begin
            chk_ctl($sformatf("single%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("single%0d.data", i), 32'(out_data), 32'hA5);
            chk($sformatf("single%0d.beat", i), 32'(dut.r_beat_cnt), 32'(i % 4));
            step();
        end

        // Release to IDLE, then B alone; sel holds its value in IDLE
        req_a = 1'b0;
        step();
        chk_ctl("idle_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        req_b = 1'b1;
        step();
        chk_ctl("only_b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        req_b = 1'b0;
        step();
        chk_ctl("idle_b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
